// File: rtl/watch_pkg.sv
// Shared encodings and default timing constants for the watch mode sequencer.
// Mode values are what the display/counter blocks decode directly.
package watch_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'b00,
        MODE_SET       = 2'b01,
        MODE_STOPWATCH = 2'b10,
        MODE_ALARM     = 2'b11
    } mode_e;

    // 50 MHz core: 100 Hz tick, 20 ms debounce window.
    localparam int TICK_DIV_DEF  = 500000;
    localparam int DB_CYCLES_DEF = 1000000;

    function automatic mode_e next_mode(input mode_e m);
        mode_e n;
        case (m)
            MODE_CLOCK:     n = MODE_SET;
            MODE_SET:       n = MODE_STOPWATCH;
            MODE_STOPWATCH: n = MODE_ALARM;
            default:        n = MODE_CLOCK;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/btn_cond.sv
// Raw button -> one-cycle press pulse: 2-flop sync, optional debounce (WATCH_DEBOUNCE_EN), rising-edge detect.
// Latency 3 cycles from raw rise (2 + DB_CYCLES + 1 with debounce); no backpressure, a held button yields one pulse.
module btn_cond
    import watch_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    logic r_sync1;
    logic r_sync2;
    logic r_lvl_d;
    logic r_press;
    logic w_lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef WATCH_DEBOUNCE_EN
    localparam int DB_W = $clog2(DB_CYCLES);

    logic [DB_W-1:0] r_db_cnt;
    logic            r_stable;

    // Any cycle that agrees with the accepted level restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt <= '0;
            r_stable <= 1'b0;
        end else if (r_sync2 != r_stable) begin
            if (r_db_cnt == DB_W'(DB_CYCLES - 1)) begin
                r_stable <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    assign w_lvl = r_stable;
`else
    assign w_lvl = r_sync2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lvl_d <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_lvl_d <= w_lvl;
            r_press <= w_lvl & ~r_lvl_d;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/watch_mode_ctrl.sv
// Watch sequencer: conditions three buttons, steps clock/set/stopwatch/alarm, drives stopwatch run/clear and tick.
// Outputs update one cycle after an internal press pulse; no backpressure. Debounce via WATCH_DEBOUNCE_EN.
module watch_mode_ctrl
    import watch_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_start,
    input  logic       btn_clr,
    output logic [1:0] mode,
    output logic       start_pause,
    output logic       clr,
    output logic       tick
);

    localparam int TW = $clog2(TICK_DIV);

    logic w_press_mode;
    logic w_press_start;
    logic w_press_clr;
    logic w_in_sw;
    logic w_start_eff;
    logic w_clr_eff;
    logic w_tick;

    mode_e           r_mode;
    logic            r_start_pause;
    logic            r_clr;
    logic [TW-1:0]   r_tick_cnt;

    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_mode (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_mode),
        .o_press (w_press_mode)
    );

    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_start (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_start),
        .o_press (w_press_start)
    );

    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_clr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_clr),
        .o_press (w_press_clr)
    );

    // A mode press in the same cycle wins over start and clear.
    assign w_in_sw     = (r_mode == MODE_STOPWATCH);
    assign w_start_eff = w_press_start & w_in_sw & ~w_press_mode;
    assign w_clr_eff   = w_press_clr   & w_in_sw & ~w_press_mode;
    assign w_tick      = (r_tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_clr_eff || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode        <= MODE_CLOCK;
            r_start_pause <= 1'b1;
            r_clr         <= 1'b0;
        end else begin
            if (w_press_mode) begin
                r_mode <= next_mode(r_mode);
                if (w_in_sw) begin
                    r_start_pause <= 1'b1;
                end
            end else if (w_start_eff) begin
                r_start_pause <= ~r_start_pause;
            end

            // Held until a tick has been seen so a tick-paced counter samples it.
            if (w_clr_eff) begin
                r_clr <= 1'b1;
            end else if (w_tick) begin
                r_clr <= 1'b0;
            end
        end
    end

    assign mode        = r_mode;
    assign start_pause = r_start_pause;
    assign clr         = r_clr;
    assign tick        = w_tick;

endmodule

// File: doc/watch_mode_ctrl.md
Name: watch_mode_ctrl

Overview:
- Top-level sequencer for the digital-watch display path.
- Conditions three raw push-buttons and steps the system mode: clock, time-set, stopwatch, alarm.
- Generates the stopwatch control signals `mode`, `start_pause` and `clr`, plus a periodic `tick` enable that paces the stopwatch count.
- Sits between the board buttons and the stopwatch/clock counters; no display logic.

Parameters:
- TICK_DIV, 500000, clk cycles per tick pulse (50 MHz / 500000 = 100 Hz); legal range ≥2.
- DB_CYCLES, 1000000, stable-level cycles required to accept a button (20 ms at 50 MHz); used only with debounce compiled in; legal range ≥2.

Ports:
- clk  input  1  system clock, single domain
- rst_n  input  1  reset, asynchronous assert, active-low
- btn_mode  input  1  raw mode button, active-high, asynchronous to clk
- btn_start  input  1  raw start/pause button, active-high, asynchronous
- btn_clr  input  1  raw clear button, active-high, asynchronous
- mode  output  2  00 clock, 01 set, 10 stopwatch, 11 alarm
- start_pause  output  1  0 = stopwatch running, 1 = paused
- clr  output  1  stopwatch clear request, level
- tick  output  1  one-cycle pulse every TICK_DIV cycles

Behaviour:
- Reset (rst_n low, asynchronous):
  - mode=00, start_pause=1, clr=0, tick=0.
  - Tick counter, synchronizers and edge registers all cleared.
  - Deassertion takes effect on the next clk edge.
- Button conditioning, per button:
  - 2-flop synchronizer, then rising-edge detect.
  - Produces a one-cycle internal press pulse 3 clk cycles after the raw rise.
  - Holding a button gives exactly one press; a release produces nothing.
- Mode FSM, states CLOCK(00) → SET(01) → STOPWATCH(10) → ALARM(11) → CLOCK:
  - Advances one state per mode press; `mode` is a registered output that updates on the cycle after the press pulse.
  - Leaving STOPWATCH forces start_pause=1 in the same cycle the mode changes.
- Run control:
  - A start press toggles start_pause only while mode==10.
  - Start presses in any other mode are ignored.
- Clear:
  - A clr press is effective only while mode==10.
  - On an effective press, clr goes to 1 on the next cycle and the tick counter restarts from 0.
  - clr stays 1 until the cycle after the next tick pulse, so a tick-paced stopwatch is guaranteed to sample it.
  - Clear does not change start_pause.
  - A repeated clr press while clr is already 1 restarts the tick counter again and keeps clr high.
- Tick generation:
  - Counter runs 0..TICK_DIV-1 in every mode and wraps to 0.
  - tick=1 for exactly the cycle in which the count equals TICK_DIV-1.
- Simultaneous press pulses in the same cycle:
  - mode + start: the mode change applies and the start press is dropped. Leaving STOPWATCH therefore forces start_pause=1.
  - mode + clr: the mode change applies and the clr press is dropped.
  - start + clr in STOPWATCH: both apply; start_pause toggles and clr asserts.
- Reset mid-operation: all state returns to reset values immediately, including mid-clr and mid-debounce.

Optional Feature:
- WATCH_DEBOUNCE_EN defined:
  - After synchronization, each button passes through a stability counter.
  - The conditioned level changes only after the synchronized input has held a new value for DB_CYCLES consecutive cycles.
  - A glitch shorter than DB_CYCLES resets the counter and causes no press.
  - Press latency becomes 2 + DB_CYCLES + 1 cycles.
- WATCH_DEBOUNCE_EN undefined: synchronizer plus edge detect only; DB_CYCLES is unused.

Decomposition:
- Shared package `watch_pkg`:
  - Mode encodings MODE_CLOCK=2'b00, MODE_SET=2'b01, MODE_STOPWATCH=2'b10, MODE_ALARM=2'b11.
  - Default TICK_DIV and DB_CYCLES constants.
- Sub-module `btn_cond`:
  - Contains the synchronizer, the optional debounce and the edge detect; outputs a one-cycle press pulse.
  - Instantiated three times.
- FSM, run/clear control and tick divider stay in the top module.

Test Plan:
- Bench parameters: TICK_DIV=4, DB_CYCLES=8.
- Reset then 5 mode presses → `mode` sequence 00, 01, 10, 11, 00, 01; start_pause=1 throughout.
- In mode 10, start press → start_pause 1→0 on the cycle after the press pulse; second press → 0→1; start press in mode 00 → no change.
- In mode 10 and running, clr press mid-tick → clr=1, tick counter restarts so the next tick is 4 cycles later, and clr=0 one cycle after that tick; start_pause stays 0.
- In mode 10 and running, mode and start pulses in the same cycle → mode=11 and start_pause=1.
- Hold btn_start high for 50 cycles → exactly one toggle. With WATCH_DEBOUNCE_EN, a 5-cycle glitch → no toggle, and a 10-cycle level → one toggle at latency 11.
- Assert rst_n=0 while clr=1 in mode 10 → clr=0, mode=00 and start_pause=1 immediately, with no clk edge required.
